// File: rtl/arp_scheduler.sv
// ============================================================================
// Module : arp_scheduler
// Steps one tone voice through the held keys (up / down / up-down / mono).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arp_scheduler #(
  parameter logic [31:0] CLOCK_SPEED = 32'd50000000,
  parameter logic [31:0] STEP_HZ     = 32'd8,
  parameter logic [31:0] GAP_CYCLES  = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keys,
  input  logic [1:0]  mode,
  output logic [3:0]  tone,
  output logic        gate,
  output logic        step_strobe
);

  localparam logic [31:0] c_STEP_CYCLES = CLOCK_SPEED / STEP_HZ;
  localparam logic [31:0] c_LAST        = c_STEP_CYCLES - 32'd1;
  localparam logic [31:0] c_PLAY_END    = c_STEP_CYCLES - GAP_CYCLES - 32'd1;

  localparam logic [1:0] c_MODE_UP     = 2'b00;
  localparam logic [1:0] c_MODE_DOWN   = 2'b01;
  localparam logic [1:0] c_MODE_UPDOWN = 2'b10;
  localparam logic [1:0] c_MODE_MONO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_tone;
  logic        r_gate;
  logic        r_strobe;
  logic [31:0] r_timer;
  logic        r_dir_down;
  logic [15:0] r_keys_q;

  state_t      w_nxt_state;
  logic [3:0]  w_nxt_tone;
  logic        w_nxt_gate;
  logic        w_nxt_strobe;
  logic [31:0] w_nxt_timer;
  logic        w_nxt_dir_down;

  logic [3:0]  w_lowest;
  logic [3:0]  w_highest;
  logic [3:0]  w_above;
  logic [3:0]  w_below;
  logic        w_has_low;
  logic        w_has_above;
  logic        w_has_below;
  logic [3:0]  w_sel_tone;
  logic        w_sel_down;

  // Priority search relative to the current tone, even if its key was released.
  always_comb begin
    w_lowest    = 4'd0;
    w_highest   = 4'd0;
    w_above     = 4'd0;
    w_below     = 4'd0;
    w_has_low   = 1'b0;
    w_has_above = 1'b0;
    w_has_below = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (r_keys_q[i]) begin
        if (!w_has_low) begin
          w_lowest  = 4'(i);
          w_has_low = 1'b1;
        end
        w_highest = 4'(i);
        if (!w_has_above && (i > int'(r_tone))) begin
          w_above     = 4'(i);
          w_has_above = 1'b1;
        end
        if (i < int'(r_tone)) begin
          w_below     = 4'(i);
          w_has_below = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_tone = r_tone;
    w_sel_down = r_dir_down;
    case (mode)
      c_MODE_UP:   w_sel_tone = w_has_above ? w_above : w_lowest;
      c_MODE_DOWN: w_sel_tone = w_has_below ? w_below : w_highest;
      c_MODE_UPDOWN: begin
        // Flip at an endpoint so it is not repeated; a lone key repeats as-is.
        if (!r_dir_down) begin
          if (w_has_above) begin
            w_sel_tone = w_above;
          end else if (w_has_below) begin
            w_sel_tone = w_below;
            w_sel_down = 1'b1;
          end else begin
            w_sel_tone = w_lowest;
          end
        end else begin
          if (w_has_below) begin
            w_sel_tone = w_below;
          end else if (w_has_above) begin
            w_sel_tone = w_above;
            w_sel_down = 1'b0;
          end else begin
            w_sel_tone = w_highest;
          end
        end
      end
      default: w_sel_tone = w_lowest;
    endcase
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_tone     = r_tone;
    w_nxt_gate     = 1'b0;
    w_nxt_strobe   = 1'b0;
    w_nxt_timer    = r_timer;
    w_nxt_dir_down = r_dir_down;
    case (r_state)
      ST_IDLE: begin
        w_nxt_timer = 32'd0;
        if (r_keys_q != 16'd0) begin
          w_nxt_state  = ST_PLAY;
          w_nxt_gate   = 1'b1;
          w_nxt_strobe = 1'b1;
          w_nxt_tone   = (mode == c_MODE_DOWN) ? w_highest : w_lowest;
        end
      end
      ST_PLAY, ST_GAP: begin
        if (r_keys_q == 16'd0) begin
          w_nxt_state    = ST_IDLE;
          w_nxt_timer    = 32'd0;
          w_nxt_dir_down = 1'b0;
        end else if (mode == c_MODE_MONO) begin
          w_nxt_state  = ST_PLAY;
          w_nxt_gate   = 1'b1;
          w_nxt_timer  = 32'd0;
          w_nxt_tone   = w_lowest;
          w_nxt_strobe = (w_lowest != r_tone);
        end else if (r_timer == c_LAST) begin
          w_nxt_state    = ST_PLAY;
          w_nxt_gate     = 1'b1;
          w_nxt_strobe   = 1'b1;
          w_nxt_timer    = 32'd0;
          w_nxt_tone     = w_sel_tone;
          w_nxt_dir_down = w_sel_down;
        end else begin
          w_nxt_timer = r_timer + 32'd1;
          if ((r_state == ST_PLAY) && (GAP_CYCLES != 32'd0) && (r_timer == c_PLAY_END)) begin
            w_nxt_state = ST_GAP;
          end else begin
            w_nxt_gate = (r_state == ST_PLAY);
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_timer = 32'd0;
      end
    endcase
    // Direction only matters in up-down; holding it at up makes entry start upward.
    if (mode != c_MODE_UPDOWN) begin
      w_nxt_dir_down = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tone     <= 4'd0;
      r_gate     <= 1'b0;
      r_strobe   <= 1'b0;
      r_timer    <= 32'd0;
      r_dir_down <= 1'b0;
      r_keys_q   <= 16'd0;
    end else begin
      r_state    <= w_nxt_state;
      r_tone     <= w_nxt_tone;
      r_gate     <= w_nxt_gate;
      r_strobe   <= w_nxt_strobe;
      r_timer    <= w_nxt_timer;
      r_dir_down <= w_nxt_dir_down;
      r_keys_q   <= keys;
    end
  end

  assign tone        = r_tone;
  assign gate        = r_gate;
  assign step_strobe = r_strobe;

endmodule

`default_nettype wire
